// File: rtl/uif_cmd_arbiter.sv
// Two-port command scheduler for the UIF controller command channel.
// Tracks HPR/LPR/TPW credits and grants into a registered, stall-aware output stage.
module uif_cmd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 8,
    parameter int CREDIT_W   = 6,
    parameter int HPR_INIT   = 8,
    parameter int LPR_INIT   = 16,
    parameter int TPW_INIT   = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                p0_vld,
    output logic                p0_rdy,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [ID_W-1:0]     p0_id,
    input  logic [1:0]          p0_prio,
    input  logic [1:0]          p0_type,
    input  logic [1:0]          p0_bc,

    input  logic                p1_vld,
    output logic                p1_rdy,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [ID_W-1:0]     p1_id,
    input  logic [1:0]          p1_prio,
    input  logic [1:0]          p1_type,
    input  logic [1:0]          p1_bc,

    input  logic                hpr_crd_rtn,
    input  logic                lpr_crd_rtn,
    input  logic                tpw_crd_rtn,

    input  logic                uif_cmd_stall,
    output logic                uif_cmd_vld,
    output logic [ADDR_W-1:0]   uif_cmd_addr,
    output logic [ID_W-1:0]     uif_cmd_id,
    output logic [1:0]          uif_cmd_prio,
    output logic [1:0]          uif_cmd_type,
    output logic [1:0]          uif_cmd_bc,
    output logic                uif_port_num,

    output logic [CREDIT_W-1:0] hpr_credit,
    output logic [CREDIT_W-1:0] lpr_credit,
    output logic [CREDIT_W-1:0] tpw_credit,
    output logic                crd_ovf_err
);

    typedef enum logic [1:0] {
        CLS_HPR = 2'd0,
        CLS_LPR = 2'd1,
        CLS_TPW = 2'd2
    } cmd_class_t;

    localparam int SC_W = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0]     SC_LIM   = SC_W'(STARVE_LIM);
    localparam logic [CREDIT_W-1:0] HPR_CEIL = CREDIT_W'(HPR_INIT);
    localparam logic [CREDIT_W-1:0] LPR_CEIL = CREDIT_W'(LPR_INIT);
    localparam logic [CREDIT_W-1:0] TPW_CEIL = CREDIT_W'(TPW_INIT);

    function automatic cmd_class_t classify(input logic [1:0] prio, input logic [1:0] typ);
        if (typ[0])
            return CLS_TPW;
        else if (prio >= 2'd2)
            return CLS_HPR;
        else
            return CLS_LPR;
    endfunction

    function automatic logic credit_ok(input cmd_class_t cls,
                                       input logic [CREDIT_W-1:0] h,
                                       input logic [CREDIT_W-1:0] l,
                                       input logic [CREDIT_W-1:0] t);
        case (cls)
            CLS_HPR: return h != '0;
            CLS_LPR: return l != '0;
            default: return t != '0;
        endcase
    endfunction

    // Two-way pick: a lone candidate wins, a tie goes to the round-robin pointer.
    function automatic logic [1:0] pick(input logic c0, input logic c1, input logic ptr);
        if (c0 && c1)
            return ptr ? 2'b10 : 2'b01;
        return {c1, c0};
    endfunction

    function automatic logic [CREDIT_W-1:0] credit_next(input logic [CREDIT_W-1:0] cnt,
                                                        input logic take,
                                                        input logic ret,
                                                        input logic [CREDIT_W-1:0] ceil);
        if (take && !ret)
            return cnt - 1'b1;
        if (ret && !take && cnt != ceil)
            return cnt + 1'b1;
        return cnt;
    endfunction

    cmd_class_t      p0_cls, p1_cls, win_cls;
    logic            p0_elig, p1_elig;
    logic            p0_starved, p1_starved;
    logic            p0_hpr, p1_hpr;
    logic            slot_free;
    logic [1:0]      grant;
    logic            any_grant;
    logic            win_port;
    logic            rr_ptr;
    logic [SC_W-1:0] p0_starve_cnt, p1_starve_cnt;
    logic            hpr_take, lpr_take, tpw_take;
    logic            ovf_hit;

    assign p0_cls     = classify(p0_prio, p0_type);
    assign p1_cls     = classify(p1_prio, p1_type);
    assign p0_elig    = p0_vld && credit_ok(p0_cls, hpr_credit, lpr_credit, tpw_credit);
    assign p1_elig    = p1_vld && credit_ok(p1_cls, hpr_credit, lpr_credit, tpw_credit);
    assign p0_starved = p0_elig && (p0_starve_cnt >= SC_LIM);
    assign p1_starved = p1_elig && (p1_starve_cnt >= SC_LIM);
    assign p0_hpr     = p0_elig && (p0_cls == CLS_HPR);
    assign p1_hpr     = p1_elig && (p1_cls == CLS_HPR);
    assign slot_free  = !uif_cmd_vld || !uif_cmd_stall;

    // Starvation override first, then HPR, then plain round-robin.
    always_comb begin
        grant = 2'b00;
        if (slot_free) begin
            if (p0_starved || p1_starved)
                grant = pick(p0_starved, p1_starved, rr_ptr);
            else if (p0_hpr || p1_hpr)
                grant = pick(p0_hpr, p1_hpr, rr_ptr);
            else
                grant = pick(p0_elig, p1_elig, rr_ptr);
        end
    end

    assign any_grant = grant[0] || grant[1];
    assign win_port  = grant[1];
    assign win_cls   = win_port ? p1_cls : p0_cls;
    assign p0_rdy    = grant[0];
    assign p1_rdy    = grant[1];

    assign hpr_take  = any_grant && (win_cls == CLS_HPR);
    assign lpr_take  = any_grant && (win_cls == CLS_LPR);
    assign tpw_take  = any_grant && (win_cls == CLS_TPW);

    assign ovf_hit = (hpr_crd_rtn && !hpr_take && hpr_credit == HPR_CEIL) ||
                     (lpr_crd_rtn && !lpr_take && lpr_credit == LPR_CEIL) ||
                     (tpw_crd_rtn && !tpw_take && tpw_credit == TPW_CEIL);

    // A new grant may replace an accepted command in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uif_cmd_vld  <= 1'b0;
            uif_cmd_addr <= '0;
            uif_cmd_id   <= '0;
            uif_cmd_prio <= '0;
            uif_cmd_type <= '0;
            uif_cmd_bc   <= '0;
            uif_port_num <= 1'b0;
        end else if (any_grant) begin
            uif_cmd_vld  <= 1'b1;
            uif_cmd_addr <= win_port ? p1_addr : p0_addr;
            uif_cmd_id   <= win_port ? p1_id   : p0_id;
            uif_cmd_prio <= win_port ? p1_prio : p0_prio;
            uif_cmd_type <= win_port ? p1_type : p0_type;
            uif_cmd_bc   <= win_port ? p1_bc   : p0_bc;
            uif_port_num <= win_port;
        end else if (uif_cmd_vld && !uif_cmd_stall) begin
            uif_cmd_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= 1'b0;
            p0_starve_cnt <= '0;
            p1_starve_cnt <= '0;
        end else if (any_grant) begin
            rr_ptr <= !win_port;
            if (win_port) begin
                p1_starve_cnt <= '0;
                if (p0_elig && p0_starve_cnt != SC_LIM)
                    p0_starve_cnt <= p0_starve_cnt + 1'b1;
            end else begin
                p0_starve_cnt <= '0;
                if (p1_elig && p1_starve_cnt != SC_LIM)
                    p1_starve_cnt <= p1_starve_cnt + 1'b1;
            end
        end
    end

    // A same-cycle return and grant of one class cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpr_credit  <= HPR_CEIL;
            lpr_credit  <= LPR_CEIL;
            tpw_credit  <= TPW_CEIL;
            crd_ovf_err <= 1'b0;
        end else begin
            hpr_credit <= credit_next(hpr_credit, hpr_take, hpr_crd_rtn, HPR_CEIL);
            lpr_credit <= credit_next(lpr_credit, lpr_take, lpr_crd_rtn, LPR_CEIL);
            tpw_credit <= credit_next(tpw_credit, tpw_take, tpw_crd_rtn, TPW_CEIL);
            if (ovf_hit)
                crd_ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uif_cmd_arbiter.sv
// Bench for uif_cmd_arbiter: directed scenarios plus a random run against a
// queue-free, rule-level model of arbitration, credits and the output stage.
module tb_uif_cmd_arbiter;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 8;
    localparam int CW     = 6;
    localparam int LIM    = 4;

    logic              clk, rst;
    logic              p0_vld, p1_vld, p0_rdy, p1_rdy;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [ID_W-1:0]   p0_id, p1_id;
    logic [1:0]        p0_prio, p1_prio, p0_type, p1_type, p0_bc, p1_bc;
    logic              hpr_crd_rtn, lpr_crd_rtn, tpw_crd_rtn, uif_cmd_stall;
    logic              uif_cmd_vld, uif_port_num, crd_ovf_err;
    logic [ADDR_W-1:0] uif_cmd_addr;
    logic [ID_W-1:0]   uif_cmd_id;
    logic [1:0]        uif_cmd_prio, uif_cmd_type, uif_cmd_bc;
    logic [CW-1:0]     hpr_credit, lpr_credit, tpw_credit;

    int n_cmp = 0;
    int n_fail = 0;

    uif_cmd_arbiter #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .CREDIT_W(CW),
        .HPR_INIT(8), .LPR_INIT(16), .TPW_INIT(16), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_vld(p0_vld), .p0_rdy(p0_rdy), .p0_addr(p0_addr), .p0_id(p0_id),
        .p0_prio(p0_prio), .p0_type(p0_type), .p0_bc(p0_bc),
        .p1_vld(p1_vld), .p1_rdy(p1_rdy), .p1_addr(p1_addr), .p1_id(p1_id),
        .p1_prio(p1_prio), .p1_type(p1_type), .p1_bc(p1_bc),
        .hpr_crd_rtn(hpr_crd_rtn), .lpr_crd_rtn(lpr_crd_rtn), .tpw_crd_rtn(tpw_crd_rtn),
        .uif_cmd_stall(uif_cmd_stall), .uif_cmd_vld(uif_cmd_vld),
        .uif_cmd_addr(uif_cmd_addr), .uif_cmd_id(uif_cmd_id),
        .uif_cmd_prio(uif_cmd_prio), .uif_cmd_type(uif_cmd_type), .uif_cmd_bc(uif_cmd_bc),
        .uif_port_num(uif_port_num),
        .hpr_credit(hpr_credit), .lpr_credit(lpr_credit), .tpw_credit(tpw_credit),
        .crd_ovf_err(crd_ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: class index 0=HPR 1=LPR 2=TPW.
    int          m_crd[3];
    int          m_init[3] = '{8, 16, 16};
    int          m_starve[2];
    int          m_fav;
    bit          m_vld, m_ovf;
    int          m_port;
    logic [31:0] m_addr;
    logic [7:0]  m_id;
    logic [1:0]  m_prio, m_type, m_bc;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) m_crd[k] = m_init[k];
        m_starve[0] = 0; m_starve[1] = 0;
        m_fav = 0; m_vld = 0; m_ovf = 0; m_port = 0;
        m_addr = '0; m_id = '0; m_prio = '0; m_type = '0; m_bc = '0;
    endfunction

    function automatic int cls_of(input logic [1:0] prio, input logic [1:0] typ);
        if (typ[0]) return 2;
        if (prio >= 2'd2) return 0;
        return 1;
    endfunction

    function automatic int choose(input bit a0, input bit a1);
        if (a0 && a1) return m_fav;
        if (a0) return 0;
        if (a1) return 1;
        return -1;
    endfunction

    function automatic int model_pick();
        int c[2];
        bit e[2], s[2], h[2];
        if (m_vld && uif_cmd_stall) return -1;
        c[0] = cls_of(p0_prio, p0_type);
        c[1] = cls_of(p1_prio, p1_type);
        e[0] = p0_vld && m_crd[c[0]] > 0;
        e[1] = p1_vld && m_crd[c[1]] > 0;
        for (int n = 0; n < 2; n++) begin
            s[n] = e[n] && m_starve[n] >= LIM;
            h[n] = e[n] && c[n] == 0;
        end
        if (s[0] || s[1]) return choose(s[0], s[1]);
        if (h[0] || h[1]) return choose(h[0], h[1]);
        return choose(e[0], e[1]);
    endfunction

    function automatic void model_commit(input int g);
        int  c[2];
        bit  e[2];
        bit  rtn[3];
        int  wc;
        bit  take;
        c[0] = cls_of(p0_prio, p0_type);
        c[1] = cls_of(p1_prio, p1_type);
        e[0] = p0_vld && m_crd[c[0]] > 0;
        e[1] = p1_vld && m_crd[c[1]] > 0;
        rtn[0] = hpr_crd_rtn; rtn[1] = lpr_crd_rtn; rtn[2] = tpw_crd_rtn;
        wc = (g == 1) ? c[1] : c[0];
        for (int k = 0; k < 3; k++) begin
            take = (g >= 0) && (wc == k);
            if (take && !rtn[k]) m_crd[k] = m_crd[k] - 1;
            else if (rtn[k] && !take) begin
                if (m_crd[k] == m_init[k]) m_ovf = 1;
                else m_crd[k] = m_crd[k] + 1;
            end
        end
        if (g >= 0) begin
            m_vld  = 1;
            m_port = g;
            m_addr = (g == 1) ? p1_addr : p0_addr;
            m_id   = (g == 1) ? p1_id   : p0_id;
            m_prio = (g == 1) ? p1_prio : p0_prio;
            m_type = (g == 1) ? p1_type : p0_type;
            m_bc   = (g == 1) ? p1_bc   : p0_bc;
            m_fav  = 1 - g;
            m_starve[g] = 0;
            if (e[1-g] && m_starve[1-g] < LIM) m_starve[1-g] = m_starve[1-g] + 1;
        end else if (m_vld && !uif_cmd_stall) begin
            m_vld = 0;
        end
    endfunction

    task automatic idle_inputs();
        p0_vld = 0; p1_vld = 0;
        p0_addr = '0; p1_addr = '0; p0_id = '0; p1_id = '0;
        p0_prio = '0; p1_prio = '0; p0_type = '0; p1_type = '0; p0_bc = '0; p1_bc = '0;
        hpr_crd_rtn = 0; lpr_crd_rtn = 0; tpw_crd_rtn = 0; uif_cmd_stall = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic set_port(input int n, input bit vld, input logic [1:0] prio, input logic [1:0] typ);
        if (n == 0) begin
            p0_vld = vld; p0_prio = prio; p0_type = typ;
            p0_addr = $urandom(); p0_id = 8'($urandom()); p0_bc = 2'($urandom());
        end else begin
            p1_vld = vld; p1_prio = prio; p1_type = typ;
            p1_addr = $urandom(); p1_id = 8'($urandom()); p1_bc = 2'($urandom());
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (hpr_credit !== 6'd8)  begin n_fail++; $display("[TB] FAIL reset_hpr: got %0d want 8", hpr_credit); end
        n_cmp++; if (lpr_credit !== 6'd16) begin n_fail++; $display("[TB] FAIL reset_lpr: got %0d want 16", lpr_credit); end
        n_cmp++; if (tpw_credit !== 6'd16) begin n_fail++; $display("[TB] FAIL reset_tpw: got %0d want 16", tpw_credit); end
        n_cmp++; if (uif_cmd_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vld: got %b want 0", uif_cmd_vld); end
        n_cmp++; if ({p0_rdy, p1_rdy} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b%b want 00", p0_rdy, p1_rdy); end
        n_cmp++; if (uif_cmd_addr !== '0 || uif_port_num !== 1'b0 || crd_ovf_err !== 1'b0)
            begin n_fail++; $display("[TB] FAIL reset_out: addr %h port %b ovf %b want 0/0/0", uif_cmd_addr, uif_port_num, crd_ovf_err); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        int exp_port;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_port(0, 1, 2'd0, 2'd0);
            set_port(1, 1, 2'd1, 2'd2);
            exp_port = i % 2;
            exp_addr = (exp_port == 1) ? p1_addr : p0_addr;
            #1;
            n_cmp++; if (p0_rdy !== (exp_port == 0) || p1_rdy !== (exp_port == 1))
                begin n_fail++; $display("[TB] FAIL rr_rdy[%0d]: got %b%b want port %0d", i, p1_rdy, p0_rdy, exp_port); end
            @(posedge clk); #1;
            n_cmp++; if (uif_port_num !== 1'(exp_port) || uif_cmd_vld !== 1'b1 || uif_cmd_addr !== exp_addr)
                begin n_fail++; $display("[TB] FAIL rr_out[%0d]: port %b vld %b addr %h want %0d/1/%h", i, uif_port_num, uif_cmd_vld, uif_cmd_addr, exp_port, exp_addr); end
            n_cmp++; if (lpr_credit !== CW'(15 - i))
                begin n_fail++; $display("[TB] FAIL rr_lpr[%0d]: got %0d want %0d", i, lpr_credit, 15 - i); end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_priority_starve();
        int exp_port;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_port(0, 1, 2'd3, 2'd0);
            set_port(1, 1, 2'd0, 2'd0);
            exp_port = (i % 5 == 4) ? 1 : 0;
            hpr_crd_rtn = (exp_port == 0);
            #1;
            n_cmp++; if (p0_rdy !== (exp_port == 0) || p1_rdy !== (exp_port == 1))
                begin n_fail++; $display("[TB] FAIL starve_rdy[%0d]: got %b%b want port %0d", i, p1_rdy, p0_rdy, exp_port); end
            @(posedge clk); #1;
            n_cmp++; if (uif_port_num !== 1'(exp_port) || hpr_credit !== 6'd8)
                begin n_fail++; $display("[TB] FAIL starve_out[%0d]: port %b hpr %0d want %0d/8", i, uif_port_num, hpr_credit, exp_port); end
        end
        n_cmp++; if (lpr_credit !== 6'd13) begin n_fail++; $display("[TB] FAIL starve_lpr: got %0d want 13", lpr_credit); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_stall();
        logic [31:0] a_addr, b_addr;
        logic [7:0]  a_id;
        do_reset();
        @(negedge clk);
        set_port(0, 1, 2'd0, 2'd0);
        a_addr = p0_addr; a_id = p0_id;
        #1;
        n_cmp++; if (p0_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_first: got %b want 1", p0_rdy); end
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            uif_cmd_stall = 1;
            set_port(0, 1, 2'd0, 2'd0);
            set_port(1, 1, 2'd0, 2'd0);
            #1;
            n_cmp++; if ({p0_rdy, p1_rdy} !== 2'b00)
                begin n_fail++; $display("[TB] FAIL stall_rdy[%0d]: got %b%b want 00", i, p0_rdy, p1_rdy); end
            @(posedge clk); #1;
            n_cmp++; if (uif_cmd_vld !== 1'b1 || uif_cmd_addr !== a_addr || uif_cmd_id !== a_id || uif_port_num !== 1'b0 || lpr_credit !== 6'd15)
                begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: vld %b addr %h id %h lpr %0d want 1/%h/%h/15", i, uif_cmd_vld, uif_cmd_addr, uif_cmd_id, lpr_credit, a_addr, a_id); end
        end
        @(negedge clk);
        uif_cmd_stall = 0;
        b_addr = p1_addr;
        #1;
        n_cmp++; if ({p0_rdy, p1_rdy} !== 2'b01)
            begin n_fail++; $display("[TB] FAIL stall_release: got p0 %b p1 %b want p1", p0_rdy, p1_rdy); end
        @(posedge clk); #1;
        n_cmp++; if (uif_cmd_addr !== b_addr || uif_port_num !== 1'b1 || lpr_credit !== 6'd14)
            begin n_fail++; $display("[TB] FAIL stall_next: addr %h port %b lpr %0d want %h/1/14", uif_cmd_addr, uif_port_num, lpr_credit, b_addr); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_credit_exhaust();
        int wins;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_port(0, 1, 2'($urandom()), 2'd1);
            #1;
            n_cmp++; if (p0_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL exh_write[%0d]: got %b want 1", i, p0_rdy); end
            @(posedge clk); #1;
            n_cmp++; if (tpw_credit !== CW'(15 - i)) begin n_fail++; $display("[TB] FAIL exh_tpw[%0d]: got %0d want %0d", i, tpw_credit, 15 - i); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_port(0, 1, 2'd0, 2'd1);
            set_port(1, 1, 2'd0, 2'd0);
            #1;
            n_cmp++; if ({p0_rdy, p1_rdy} !== 2'b01)
                begin n_fail++; $display("[TB] FAIL exh_block[%0d]: got p0 %b p1 %b want p1", i, p0_rdy, p1_rdy); end
            @(posedge clk);
        end
        @(negedge clk);
        p1_vld = 0;
        tpw_crd_rtn = 1;
        #1;
        n_cmp++; if (p0_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL exh_rtn_cycle: got %b want 0", p0_rdy); end
        @(posedge clk); #1;
        n_cmp++; if (tpw_credit !== 6'd1) begin n_fail++; $display("[TB] FAIL exh_rtn: got %0d want 1", tpw_credit); end
        wins = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tpw_crd_rtn = 0;
            set_port(0, 1, 2'd0, 2'd1);
            #1;
            if (p0_rdy === 1'b1) wins++;
            @(posedge clk);
        end
        #1;
        n_cmp++; if (wins != 1 || tpw_credit !== 6'd0)
            begin n_fail++; $display("[TB] FAIL exh_one_more: wins %0d tpw %0d want 1/0", wins, tpw_credit); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_credit_edges();
        do_reset();
        @(negedge clk);
        set_port(0, 1, 2'd0, 2'd1);
        tpw_crd_rtn = 1;
        #1;
        n_cmp++; if (p0_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL edge_grant: got %b want 1", p0_rdy); end
        @(posedge clk); #1;
        n_cmp++; if (tpw_credit !== 6'd16 || crd_ovf_err !== 1'b0)
            begin n_fail++; $display("[TB] FAIL edge_cancel: tpw %0d ovf %b want 16/0", tpw_credit, crd_ovf_err); end
        @(negedge clk);
        p0_vld = 0;
        tpw_crd_rtn = 1;
        @(posedge clk); #1;
        n_cmp++; if (tpw_credit !== 6'd16 || crd_ovf_err !== 1'b1)
            begin n_fail++; $display("[TB] FAIL edge_ovf: tpw %0d ovf %b want 16/1", tpw_credit, crd_ovf_err); end
        @(negedge clk);
        tpw_crd_rtn = 0;
        set_port(0, 1, 2'd0, 2'd0);
        @(posedge clk); #1;
        n_cmp++; if (uif_cmd_vld !== 1'b1 || lpr_credit !== 6'd15 || crd_ovf_err !== 1'b1)
            begin n_fail++; $display("[TB] FAIL edge_load: vld %b lpr %0d ovf %b want 1/15/1", uif_cmd_vld, lpr_credit, crd_ovf_err); end
        @(negedge clk);
        p0_vld = 0;
        uif_cmd_stall = 1;
        rst = 1;
        @(posedge clk); #1;
        n_cmp++; if (uif_cmd_vld !== 1'b0 || lpr_credit !== 6'd16 || crd_ovf_err !== 1'b0)
            begin n_fail++; $display("[TB] FAIL edge_rst: vld %b lpr %0d ovf %b want 0/16/0", uif_cmd_vld, lpr_credit, crd_ovf_err); end
        @(negedge clk);
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_port(0, ($urandom_range(0, 9) < 7), 2'($urandom()), 2'($urandom()));
            set_port(1, ($urandom_range(0, 9) < 7), 2'($urandom()), 2'($urandom()));
            hpr_crd_rtn   = ($urandom_range(0, 3) == 0);
            lpr_crd_rtn   = ($urandom_range(0, 3) == 0);
            tpw_crd_rtn   = ($urandom_range(0, 3) == 0);
            uif_cmd_stall = ($urandom_range(0, 9) < 3);
            #1;
            g = model_pick();
            n_cmp++; if (p0_rdy !== (g == 0) || p1_rdy !== (g == 1))
                begin n_fail++; $display("[TB] FAIL rand_rdy[%0d]: got %b%b want grant %0d", i, p1_rdy, p0_rdy, g); end
            @(posedge clk);
            model_commit(g);
            #1;
            n_cmp++; if (uif_cmd_vld !== m_vld)
                begin n_fail++; $display("[TB] FAIL rand_vld[%0d]: got %b want %b", i, uif_cmd_vld, m_vld); end
            if (m_vld) begin
                n_cmp++; if (uif_cmd_addr !== m_addr || uif_cmd_id !== m_id || uif_cmd_prio !== m_prio ||
                             uif_cmd_type !== m_type || uif_cmd_bc !== m_bc || uif_port_num !== 1'(m_port))
                    begin n_fail++; $display("[TB] FAIL rand_payload[%0d]: addr %h port %b want %h/%0d", i, uif_cmd_addr, uif_port_num, m_addr, m_port); end
            end
            n_cmp++; if (hpr_credit !== CW'(m_crd[0]) || lpr_credit !== CW'(m_crd[1]) ||
                         tpw_credit !== CW'(m_crd[2]) || crd_ovf_err !== m_ovf)
                begin n_fail++; $display("[TB] FAIL rand_credit[%0d]: got %0d/%0d/%0d ovf %b want %0d/%0d/%0d ovf %b",
                                         i, hpr_credit, lpr_credit, tpw_credit, crd_ovf_err, m_crd[0], m_crd[1], m_crd[2], m_ovf); end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_priority_starve();
        test_stall();
        test_credit_exhaust();
        test_credit_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
